// File: rtl/driver_pkg.sv
// Shared opcodes, data width and issuer state encoding for the driver command path.
package driver_pkg;

  localparam int DW = 32;

  localparam logic [31:0] OPC_NOP = 32'd0;
  localparam logic [31:0] OPC_WR  = 32'd1;
  localparam logic [31:0] OPC_ADD = 32'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/issuer_rsp_fifo.sv
// Synchronous response FIFO. Pointers wrap modulo DEPTH.
// Push while full is accepted only when a pop frees the head slot in the same cycle.
// A pop on an empty FIFO is ignored, so a same-cycle push into an empty FIFO shows up next cycle.
module issuer_rsp_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign dout    = mem[rptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; reset flushes the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/driver_cmd_issuer.sv
// Issues stream commands onto the driver port, one registered cycle each.
// ADD results are sampled RESULT_LAT cycles after the ADD cycle and queued with their id.
// Handshakes: a transfer happens on a rising edge where valid && ready; ready never waits on valid.
module driver_cmd_issuer #(
  parameter int DW         = driver_pkg::DW,
  parameter int RESULT_LAT = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_opcode,
  input  logic [DW-1:0] cmd_id,
  input  logic [DW-1:0] cmd_in,
  input  logic [DW-1:0] cmd_addr,
  output logic [DW-1:0] drv_opcode,
  output logic [DW-1:0] drv_id,
  output logic [DW-1:0] drv_in,
  output logic [DW-1:0] drv_addr,
  input  logic [DW-1:0] drv_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic [7:0]    err_cnt,
  output logic          dbg_state
);

  import driver_pkg::*;

  localparam int LAT_W = $clog2(RESULT_LAT + 1);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [DW-1:0]    add_id_q, add_id_d;
  logic [7:0]       err_q, err_d;
  logic [DW-1:0]    opc_d, id_d, in_d, addr_d;
  logic             push_req;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [2*DW-1:0]  fifo_dout;
  logic             rsp_free;
  logic             is_nop, is_wr, is_add;

  assign is_nop   = (cmd_opcode == DW'(OPC_NOP));
  assign is_wr    = (cmd_opcode == DW'(OPC_WR));
  assign is_add   = (cmd_opcode == DW'(OPC_ADD));
  assign rsp_free = (fifo_count < CNT_W'(RSP_DEPTH));

  // lat_cnt holds the cycles still to go before drv_out carries the ADD result.
  // It is loaded with RESULT_LAT for the ADD cycle itself, so the sample happens when it reaches 0.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    add_id_d  = add_id_q;
    err_d     = err_q;
    opc_d     = '0;
    id_d      = '0;
    in_d      = '0;
    addr_d    = '0;
    cmd_ready = 1'b0;
    push_req  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !reset && (!is_add || rsp_free);
        if (cmd_valid && cmd_ready) begin
          if (is_wr || is_add) begin
            opc_d  = cmd_opcode;
            id_d   = cmd_id;
            in_d   = cmd_in;
            addr_d = cmd_addr;
          end
          if (is_add) begin
            add_id_d = cmd_id;
            lat_d    = LAT_W'(RESULT_LAT);
            state_d  = WAIT;
          end else if (!is_wr && !is_nop && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          push_req = 1'b1;
          state_d  = IDLE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
    endcase
  end

  // FSM state, counters and the registered driver port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      add_id_q   <= '0;
      err_q      <= '0;
      drv_opcode <= '0;
      drv_id     <= '0;
      drv_in     <= '0;
      drv_addr   <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      add_id_q   <= add_id_d;
      err_q      <= err_d;
      drv_opcode <= opc_d;
      drv_id     <= id_d;
      drv_in     <= in_d;
      drv_addr   <= addr_d;
    end
  end

  // The slot was reserved at ADD accept; the full gate is only a backstop.
  assign fifo_push = push_req && !fifo_full;

  issuer_rsp_fifo #(
    .WIDTH (2*DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   ({add_id_q, drv_out}),
    .pop   (rsp_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = fifo_empty ? '0 : fifo_dout[2*DW-1:DW];
  assign rsp_data  = fifo_empty ? '0 : fifo_dout[DW-1:0];
  assign busy      = (state_q != IDLE) || (drv_opcode != '0);
  assign err_cnt   = err_q;
  assign dbg_state = (state_q == WAIT);

endmodule

// File: tb/tb_driver_cmd_issuer.sv
// Bench for driver_cmd_issuer with a small behavioural driver:
// WR shifts the operand pair (op1 <= op0, op0 <= in), ADD registers op0+op1 onto out one cycle later.
module tb_driver_cmd_issuer;

  localparam int DW = 32;
  localparam logic [31:0] OP_NOP = 32'd0;
  localparam logic [31:0] OP_WR  = 32'd1;
  localparam logic [31:0] OP_ADD = 32'd2;

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_opcode, cmd_id, cmd_in, cmd_addr;
  logic [DW-1:0] drv_opcode, drv_id, drv_in, drv_addr, drv_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_id, rsp_data;
  logic          busy;
  logic [7:0]    err_cnt;
  logic          dbg_state;

  int pass_cnt;
  int total_cnt;
  logic [2*DW-1:0] exp_q[$];

  driver_cmd_issuer #(.DW(DW), .RESULT_LAT(1), .RSP_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_id     (cmd_id),
    .cmd_in     (cmd_in),
    .cmd_addr   (cmd_addr),
    .drv_opcode (drv_opcode),
    .drv_id     (drv_id),
    .drv_in     (drv_in),
    .drv_addr   (drv_addr),
    .drv_out    (drv_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // Behavioural driver
  logic [DW-1:0] op0, op1;
  always @(posedge clock) begin
    if (reset) begin
      op0     <= '0;
      op1     <= '0;
      drv_out <= '0;
    end else if (drv_opcode == OP_WR) begin
      op1 <= op0;
      op0 <= drv_in;
    end else if (drv_opcode == OP_ADD) begin
      drv_out <= op0 + op1;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [31:0] op, input logic [31:0] id,
                         input logic [31:0] din, input logic [31:0] addr);
    cmd_valid  = v;
    cmd_opcode = op;
    cmd_id     = id;
    cmd_in     = din;
    cmd_addr   = addr;
  endtask

  task automatic idle_cmd();
    set_cmd(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rsp_ready = 1'b0;
    idle_cmd();
    step();
    step();
    reset = 1'b0;
  endtask

  // Presents one command, waits (bounded) for ready, completes the transfer.
  // Returns one cycle after the accepting edge, with the command on drv_*.
  task automatic issue(input logic [31:0] op, input logic [31:0] id,
                       input logic [31:0] din, input logic [31:0] addr);
    int n;
    n = 0;
    set_cmd(1'b1, op, id, din, addr);
    #1;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    check("issue_ready", {63'd0, cmd_ready}, 64'd1);
    step();
    idle_cmd();
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check(name, {63'd0, rsp_valid}, 64'd1);
  endtask

  // Scoreboard pop: compares the head against the expected queue, then pops it.
  task automatic pop_check(input string name);
    logic [2*DW-1:0] exp;
    exp = exp_q.pop_front();
    check({name, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    check({name, "_id"},   {32'd0, rsp_id},   {32'd0, exp[2*DW-1:DW]});
    check({name, "_data"}, {32'd0, rsp_data}, {32'd0, exp[DW-1:0]});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] opcode;
    logic [31:0] id;
    logic [31:0] din;
    logic [31:0] addr;
    logic        exp_ready;
    logic [31:0] exp_opc;
    logic [31:0] exp_id;
    logic [31:0] exp_in;
    logic [31:0] exp_addr;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] sums[5];
  logic        drv_seen;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0] = '{32'd1, 32'h11, 32'hA5, 32'h4, 1'b1, 32'd1, 32'h11, 32'hA5, 32'h4, 8'd0};
    vecs[1] = '{32'd0, 32'h22, 32'h5A, 32'h8, 1'b1, 32'd0, 32'h0, 32'h0, 32'h0, 8'd0};
    vecs[2] = '{32'd3, 32'h33, 32'h1, 32'h1, 1'b1, 32'd0, 32'h0, 32'h0, 32'h0, 8'd1};
    vecs[3] = '{32'hFFFFFFFF, 32'h44, 32'h2, 32'h2, 1'b1, 32'd0, 32'h0, 32'h0, 32'h0, 8'd2};
    vecs[4] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
                32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd2};
    vecs[5] = '{32'd7, 32'h55, 32'h3, 32'h3, 1'b1, 32'd0, 32'h0, 32'h0, 32'h0, 8'd3};
    sums    = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9};

    // Reset state, sampled while reset is held
    reset     = 1'b1;
    rsp_ready = 1'b0;
    idle_cmd();
    step();
    step();
    check("rst_drv_opcode", {32'd0, drv_opcode}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_state", {63'd0, dbg_state}, 64'd0);
    reset = 1'b0;

    // Table: single-cycle commands, back to back
    for (int i = 0; i < 6; i++) begin
      set_cmd(1'b1, vecs[i].opcode, vecs[i].id, vecs[i].din, vecs[i].addr);
      #1;
      check($sformatf("vec%0d_ready", i), {63'd0, cmd_ready}, {63'd0, vecs[i].exp_ready});
      step();
      check($sformatf("vec%0d_opc", i), {32'd0, drv_opcode}, {32'd0, vecs[i].exp_opc});
      check($sformatf("vec%0d_id", i), {32'd0, drv_id}, {32'd0, vecs[i].exp_id});
      check($sformatf("vec%0d_in", i), {32'd0, drv_in}, {32'd0, vecs[i].exp_in});
      check($sformatf("vec%0d_addr", i), {32'd0, drv_addr}, {32'd0, vecs[i].exp_addr});
      check($sformatf("vec%0d_err", i), {56'd0, err_cnt}, {56'd0, vecs[i].exp_err});
    end
    idle_cmd();
    step();
    check("vec_tail_opc", {32'd0, drv_opcode}, 64'd0);
    check("vec_tail_busy", {63'd0, busy}, 64'd0);

    // 1: WR 5, WR 6, ADD id3 -> 1,1,2,0 and response {3, 11}
    do_reset();
    issue(OP_WR, 32'd1, 32'd5, 32'd0);
    check("t1_opc0", {32'd0, drv_opcode}, 64'd1);
    issue(OP_WR, 32'd2, 32'd6, 32'd0);
    check("t1_opc1", {32'd0, drv_opcode}, 64'd1);
    issue(OP_ADD, 32'd3, 32'd0, 32'd0);
    check("t1_opc2", {32'd0, drv_opcode}, 64'd2);
    check("t1_state_wait", {63'd0, dbg_state}, 64'd1);
    check("t1_busy", {63'd0, busy}, 64'd1);
    step();
    check("t1_opc3", {32'd0, drv_opcode}, 64'd0);
    check("t1_rsp_not_yet", {63'd0, rsp_valid}, 64'd0);
    step();
    exp_q.push_back({32'd3, 32'd11});
    pop_check("t1_rsp");
    check("t1_empty", {63'd0, rsp_valid}, 64'd0);
    check("t1_idle", {63'd0, busy}, 64'd0);

    // 2: eight back-to-back WRs with valid held high
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_cmd(1'b1, OP_WR, 32'(i), 32'(i + 10), 32'(i));
      #1;
      check($sformatf("t2_ready%0d", i), {63'd0, cmd_ready}, 64'd1);
      step();
      check($sformatf("t2_opc%0d", i), {32'd0, drv_opcode}, 64'd1);
      check($sformatf("t2_in%0d", i), {32'd0, drv_in}, 64'(i + 10));
    end
    idle_cmd();
    step();
    check("t2_opc_after", {32'd0, drv_opcode}, 64'd0);
    check("t2_busy_after", {63'd0, busy}, 64'd0);

    // 3: FIFO fills with rsp_ready low; fifth ADD stalls until one pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(OP_WR, 32'h20 + 32'(k), 32'(k + 1), 32'd0);
      issue(OP_ADD, 32'h30 + 32'(k), 32'd0, 32'd0);
      exp_q.push_back({32'h30 + 32'(k), sums[k]});
    end
    issue(OP_WR, 32'h24, 32'd5, 32'd0);
    set_cmd(1'b1, OP_ADD, 32'h34, 32'd0, 32'd0);
    #1;
    check("t3_full_ready", {63'd0, cmd_ready}, 64'd0);
    step();
    step();
    step();
    check("t3_stall_ready", {63'd0, cmd_ready}, 64'd0);
    check("t3_stall_opc", {32'd0, drv_opcode}, 64'd0);
    check("t3_head_stable", {32'd0, rsp_id}, 64'h30);
    pop_check("t3_pop0");
    check("t3_ready_after_pop", {63'd0, cmd_ready}, 64'd1);
    step();
    idle_cmd();
    check("t3_add5_opc", {32'd0, drv_opcode}, 64'd2);
    check("t3_add5_id", {32'd0, drv_id}, 64'h34);
    exp_q.push_back({32'h34, sums[4]});
    step();
    step();
    pop_check("t3_pop1");
    pop_check("t3_pop2");
    pop_check("t3_pop3");
    pop_check("t3_pop4");
    check("t3_drained", {63'd0, rsp_valid}, 64'd0);

    // 4: illegal opcodes count and saturate, never reach the driver
    do_reset();
    issue(32'd7, 32'h70, 32'd0, 32'd0);
    check("t4_opc", {32'd0, drv_opcode}, 64'd0);
    check("t4_err1", {56'd0, err_cnt}, 64'd1);
    drv_seen = 1'b0;
    set_cmd(1'b1, 32'd7, 32'h71, 32'd0, 32'd0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (drv_opcode != 32'd0) drv_seen = 1'b1;
      if (i == 252) check("t4_err254", {56'd0, err_cnt}, 64'd254);
      if (i == 253) check("t4_err255", {56'd0, err_cnt}, 64'd255);
    end
    idle_cmd();
    check("t4_err_sat", {56'd0, err_cnt}, 64'd255);
    check("t4_no_drv", {63'd0, drv_seen}, 64'd0);

    // 5: reset during WAIT drops the pending ADD
    do_reset();
    issue(OP_WR, 32'h50, 32'd3, 32'd0);
    issue(OP_WR, 32'h51, 32'd4, 32'd0);
    issue(OP_ADD, 32'h55, 32'd0, 32'd0);
    check("t5_in_wait", {63'd0, dbg_state}, 64'd1);
    reset = 1'b1;
    step();
    check("t5_rst_opc", {32'd0, drv_opcode}, 64'd0);
    check("t5_rst_id", {32'd0, drv_id}, 64'd0);
    check("t5_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("t5_rst_rsp_id", {32'd0, rsp_id}, 64'd0);
    check("t5_rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    check("t5_rst_state", {63'd0, dbg_state}, 64'd0);
    check("t5_rst_ready", {63'd0, cmd_ready}, 64'd0);
    reset = 1'b0;
    step();
    step();
    check("t5_no_rsp", {63'd0, rsp_valid}, 64'd0);
    issue(OP_WR, 32'h52, 32'd8, 32'd0);
    issue(OP_WR, 32'h53, 32'd9, 32'd0);
    issue(OP_ADD, 32'h56, 32'd0, 32'd0);
    wait_rsp("t5_rsp_wait");
    exp_q.push_back({32'h56, 32'd17});
    pop_check("t5_rsp");

    // 6: driver wrap-around captured verbatim
    do_reset();
    issue(OP_WR, 32'h60, 32'hFFFFFFFF, 32'd0);
    issue(OP_WR, 32'h61, 32'd1, 32'd0);
    issue(OP_ADD, 32'h66, 32'd0, 32'd0);
    wait_rsp("t6_rsp_wait");
    exp_q.push_back({32'h66, 32'h0});
    pop_check("t6_rsp");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
